return_stack: RTL and testbench
===============================

# return_stack

Hardware return-address stack that supplies the `stack_data` operand the PC selector consumes on a return (`pc_sel = 2'b11`). The control unit pushes the return address (current PC + 1) on every call and pops on every return. The top-of-stack entry is presented combinationally, so the return target is valid in the same cycle the pop is requested. Sits beside the PC register and is clocked with it.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `WIDTH`, 16, entry width; matches the PC width.
- `clk`  input  1  system clock, rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `push`  input  1  push `push_data` at the next rising edge (call).
- `pop`  input  1  pop the top entry at the next rising edge (return).
- `clr`  input  1  synchronous flush: empties the stack and clears the error flags.
- `push_data`  input  WIDTH  return address to store.
- `stack_data`  output  WIDTH  current top entry; 0 when empty.
- `count`  output  $clog2(DEPTH)+1  number of valid entries.
- `empty`  output  1  `count == 0`.
- `full`  output  1  `count == DEPTH`.
- `overflow`  output  1  sticky; a push was attempted while `full` (without `pop`).
- `underflow`  output  1  sticky; a pop was attempted while `empty`.

## Operation
- Storage: circular buffer `mem[DEPTH]`, write pointer `sp` (log2 DEPTH bits, wraps modulo DEPTH), occupancy `count`.
- Top of stack is `mem[sp-1]` (modulo). `stack_data` = `empty ? 0 : mem[sp-1]`, driven combinationally from registered state.
- Priority at each edge: `clr` first, then push/pop.
- `clr`: sets `sp = 0`, `count = 0`, `overflow = 0`, `underflow = 0`. Memory contents are not required to be cleared.
- Push only, not full: `mem[sp] <= push_data`, `sp <= sp+1`, `count <= count+1`.
- Push only, full: governed by `RSTACK_WRAP_EN` (see Configuration). `overflow <= 1` in both builds.
- Pop only, not empty: `sp <= sp-1`, `count <= count-1`.
- Pop only, empty: no state change except `underflow <= 1`.
- Push and pop together, not empty: replace the top entry. `mem[sp-1] <= push_data`; `sp` and `count` are unchanged; no flag is set, including when full.
- Push and pop together, empty: the push is performed (`count` becomes 1) and `underflow <= 1`.
- Neither push nor pop: hold.
- Flags stay set until `clr` or reset.

## Timing
- Reset (`rst_n` low, asynchronous): `sp = 0`, `count = 0`, `overflow = 0`, `underflow = 0`. Outputs immediately read `stack_data = 0`, `empty = 1`, `full = 0`.
- Reset asserted mid-operation discards all entries. No partial write survives.
- Read latency is 0. `stack_data` reflects the top entry in the same cycle `pop` is asserted, so the PC selector loads it at the same edge the pop retires.
- After a push at edge N, `stack_data == push_data` from just after edge N.
- `count`, `empty`, `full` and the flags are registered and update at the edge that performs the operation.
- There is no handshake. `push` and `pop` are single-cycle strobes, and every cycle each is asserted counts as one operation.

## Configuration
- Macro `RSTACK_WRAP_EN`.
- Defined: a push while full overwrites the oldest entry. `mem[sp] <= push_data`, `sp <= sp+1`, `count` stays `DEPTH`, `overflow <= 1`. The most recent DEPTH return addresses stay valid, so deep recursion loses only the oldest frames.
- Undefined (default): a push while full is dropped. `mem`, `sp` and `count` are unchanged, `overflow <= 1`, and `stack_data` keeps showing the previous top.

## Test plan
- Reset then idle -> `stack_data = 0`, `empty = 1`, `count = 0`, both flags 0. Assert `rst_n` low mid-sequence after 3 pushes -> all outputs return to these values immediately, without waiting for a clock edge.
- Push 16'h0011, 16'h0022, 16'h0033, then pop in three consecutive cycles -> `stack_data` reads 0033, 0022, 0011, in the cycles where `pop` is asserted. Ends with `empty = 1` and `underflow = 0`.
- Pop on empty, then push 16'h0100 together with pop on empty -> `underflow = 1` from the first edge, `count = 1`, `stack_data = 0100`. Then `clr` -> `count = 0` and `underflow = 0`.
- With 2 entries (0x0AAA top), push 0x0BBB together with pop -> `count` stays 2, `stack_data = 0BBB`. One pop then exposes the original lower entry.
- Fill 16 entries with values 1..16, then push 17 -> `full = 1`, `overflow = 1`.
  - Default build: `stack_data = 16`, and 16 pops return 16..1.
  - `RSTACK_WRAP_EN` build: `stack_data = 17`, and 16 pops return 17..2.
- Push and pop together while full -> top replaced, `count = 16`, `overflow` unchanged from its prior value.

Source files
------------

// File: rtl/return_stack.sv
// ----------------------------------------------------------------------------
// return_stack
// Hardware return-address stack for the PC selector. The control unit pushes
// the return address on a call and pops it on a return. The top entry is
// presented combinationally, so the return target is valid in the same cycle
// the pop is requested.
//
// Storage is a circular buffer addressed by a wrapping write pointer `sp`.
// The top of stack lives at mem[sp-1]. Occupancy is tracked separately in
// `count`, which lets the full and empty states be told apart.
//
// Optional feature macro: RSTACK_WRAP_EN
//   defined   - a push while full overwrites the oldest entry, so the most
//               recent DEPTH return addresses stay valid.
//   undefined - a push while full is dropped and the previous top stays
//               visible.
// Both builds set the sticky `overflow` flag on a push while full.
// ----------------------------------------------------------------------------
module return_stack #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           stack_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry storage. It has no reset, because an entry is only ever read
    // while `count` says it is valid.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    sp;
    logic [AW-1:0]    top_addr;

    // Next-state decode results
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    sp_nxt;
    logic [CW-1:0]    count_nxt;
    logic             overflow_nxt;
    logic             underflow_nxt;

    // Status flags and the top-entry address, derived from registered state
    always_comb begin
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        top_addr = sp - AW'(1);
    end

    // Zero-latency read of the top entry. It reads 0 while the stack is empty.
    always_comb begin
        stack_data = '0;
        if (!empty) begin
            stack_data = mem[top_addr];
        end
    end

    // Operation decode: clr has priority, then the push/pop combination
    always_comb begin
        wr_en         = 1'b0;
        wr_addr       = sp;
        sp_nxt        = sp;
        count_nxt     = count;
        overflow_nxt  = overflow;
        underflow_nxt = underflow;

        if (clr) begin
            sp_nxt        = '0;
            count_nxt     = '0;
            overflow_nxt  = 1'b0;
            underflow_nxt = 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (!full) begin
                        wr_en     = 1'b1;
                        sp_nxt    = sp + AW'(1);
                        count_nxt = count + CW'(1);
                    end else begin
                        overflow_nxt = 1'b1;
`ifdef RSTACK_WRAP_EN
                        // With sp wrapped onto the oldest slot, writing at sp
                        // evicts the oldest entry while count stays at DEPTH
                        wr_en  = 1'b1;
                        sp_nxt = sp + AW'(1);
`endif
                    end
                end
                2'b01: begin
                    if (!empty) begin
                        sp_nxt    = sp - AW'(1);
                        count_nxt = count - CW'(1);
                    end else begin
                        underflow_nxt = 1'b1;
                    end
                end
                2'b11: begin
                    if (!empty) begin
                        // Return then call in the same cycle: replace the top entry
                        wr_en   = 1'b1;
                        wr_addr = top_addr;
                    end else begin
                        // Nothing to pop: the push still lands, and underflow is flagged
                        wr_en         = 1'b1;
                        sp_nxt        = sp + AW'(1);
                        count_nxt     = CW'(1);
                        underflow_nxt = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pointer, occupancy and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_nxt;
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    // Entry write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= push_data;
        end
    end

endmodule

// File: tb/tb_return_stack.sv
// ----------------------------------------------------------------------------
// tb_return_stack
// Self-checking bench for return_stack. A queue-based LIFO model (back of the
// queue = top of stack) provides every expected value. Define RSTACK_WRAP_EN
// for both the RTL and this bench to check the wrap-on-full build.
// ----------------------------------------------------------------------------
module tb_return_stack;

    localparam int D = 16;
    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          push;
    logic          pop;
    logic          clr;
    logic [W-1:0]  push_data;
    logic [W-1:0]  stack_data;
    logic [4:0]    count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    int unsigned total;
    int unsigned bad;

    // Reference model state
    logic [W-1:0] mq[$];
    logic         m_ovf;
    logic         m_unf;

    return_stack #(.DEPTH(D), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .clr        (clr),
        .push_data  (push_data),
        .stack_data (stack_data),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] m_top();
        return (mq.size() != 0) ? mq[$] : '0;
    endfunction

    function automatic logic [4:0] m_cnt();
        return 5'(mq.size());
    endfunction

    task automatic m_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Apply one stack operation to the model using the LIFO rules
    task automatic m_step(input logic p, input logic o, input logic c, input logic [W-1:0] d);
        if (c) begin
            m_reset();
        end else if (p && !o) begin
            if (mq.size() < D) begin
                mq.push_back(d);
            end else begin
                m_ovf = 1'b1;
`ifdef RSTACK_WRAP_EN
                void'(mq.pop_front());
                mq.push_back(d);
`endif
            end
        end else if (o && !p) begin
            if (mq.size() != 0) void'(mq.pop_back());
            else m_unf = 1'b1;
        end else if (p && o) begin
            if (mq.size() != 0) begin
                mq[mq.size()-1] = d;
            end else begin
                mq.push_back(d);
                m_unf = 1'b1;
            end
        end
    endtask

    // Drive one cycle of stimulus and let the model follow the same edge.
    // The task returns 1 time unit after the edge with the inputs idle.
    task automatic cycle(input logic p, input logic o, input logic c, input logic [W-1:0] d);
        push = p; pop = o; clr = c; push_data = d;
        @(posedge clk);
        m_step(p, o, c, d);
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0; push_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; push_data = '0;
        m_reset();
        #1;
        total++; if (stack_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%h exp=0000", stack_data); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if ({empty, full} !== 2'b10) begin bad++; $display("FAIL rst_empty_full got=%b exp=10", {empty, full}); end
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {overflow, underflow}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b0, 1'b0, 1'b0, '0);
        total++; if ({count, empty} !== {5'd0, 1'b1}) begin bad++; $display("FAIL idle_state got=%0d/%b exp=0/1", count, empty); end
        // Three pushes, then an asynchronous reset that takes effect between clock edges
        cycle(1'b1, 1'b0, 1'b0, 16'h1234);
        cycle(1'b1, 1'b0, 1'b0, 16'h2345);
        cycle(1'b1, 1'b0, 1'b0, 16'h3456);
        total++; if ({count, stack_data} !== {5'd3, 16'h3456}) begin bad++; $display("FAIL pre_rst got=%0d/%h exp=3/3456", count, stack_data); end
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        total++; if ({stack_data, count} !== {16'h0, 5'd0}) begin bad++; $display("FAIL midrst_data_count got=%h/%0d exp=0000/0", stack_data, count); end
        total++; if ({empty, full, overflow, underflow} !== 4'b1000) begin bad++; $display("FAIL midrst_status got=%b exp=1000", {empty, full, overflow, underflow}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lifo();
        logic [W-1:0] exp_vals [3];
        exp_vals[0] = 16'h0033; exp_vals[1] = 16'h0022; exp_vals[2] = 16'h0011;
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0011);
        cycle(1'b1, 1'b0, 1'b0, 16'h0022);
        cycle(1'b1, 1'b0, 1'b0, 16'h0033);
        for (int i = 0; i < 3; i++) begin
            // The return target must already be valid in the cycle that pop is asserted
            pop = 1'b1; #1;
            total++; if (stack_data !== exp_vals[i]) begin bad++; $display("FAIL lifo_pop%0d got=%h exp=%h", i, stack_data, exp_vals[i]); end
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
        total++; if ({empty, underflow} !== 2'b10) begin bad++; $display("FAIL lifo_end got=%b exp=10", {empty, underflow}); end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        total++; if ({underflow, count} !== {1'b1, 5'd0}) begin bad++; $display("FAIL unf_pop got=%b/%0d exp=1/0", underflow, count); end
        cycle(1'b1, 1'b1, 1'b0, 16'h0100);
        total++; if ({count, stack_data, underflow} !== {5'd1, 16'h0100, 1'b1}) begin bad++; $display("FAIL unf_pushpop got=%0d/%h/%b exp=1/0100/1", count, stack_data, underflow); end
        cycle(1'b0, 1'b0, 1'b1, '0);
        total++; if ({count, underflow, stack_data} !== {5'd0, 1'b0, 16'h0}) begin bad++; $display("FAIL unf_clr got=%0d/%b/%h exp=0/0/0000", count, underflow, stack_data); end
    endtask

    task automatic test_replace();
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0555);
        cycle(1'b1, 1'b0, 1'b0, 16'h0AAA);
        cycle(1'b1, 1'b1, 1'b0, 16'h0BBB);
        total++; if ({count, stack_data} !== {5'd2, 16'h0BBB}) begin bad++; $display("FAIL repl_top got=%0d/%h exp=2/0BBB", count, stack_data); end
        cycle(1'b0, 1'b1, 1'b0, '0);
        total++; if ({count, stack_data} !== {5'd1, 16'h0555}) begin bad++; $display("FAIL repl_lower got=%0d/%h exp=1/0555", count, stack_data); end
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL repl_flags got=%b exp=00", {overflow, underflow}); end
    endtask

    task automatic test_full();
        logic [W-1:0] first_exp;
`ifdef RSTACK_WRAP_EN
        first_exp = 16'd17;
`else
        first_exp = 16'd16;
`endif
        cycle(1'b0, 1'b0, 1'b1, '0);
        for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 1'b0, 16'(i));
        total++; if ({full, overflow, count} !== {1'b1, 1'b0, 5'd16}) begin bad++; $display("FAIL full_fill got=%b/%b/%0d exp=1/0/16", full, overflow, count); end
        // Replacing the top while full must not raise overflow
        cycle(1'b1, 1'b1, 1'b0, 16'hBEEF);
        total++; if ({stack_data, count, overflow} !== {16'hBEEF, 5'd16, 1'b0}) begin bad++; $display("FAIL full_repl got=%h/%0d/%b exp=BEEF/16/0", stack_data, count, overflow); end
        cycle(1'b1, 1'b1, 1'b0, 16'd16);
        cycle(1'b1, 1'b0, 1'b0, 16'd17);
        total++; if ({full, overflow} !== 2'b11) begin bad++; $display("FAIL full_ovf got=%b exp=11", {full, overflow}); end
        total++; if (stack_data !== first_exp) begin bad++; $display("FAIL full_top got=%0d exp=%0d", stack_data, first_exp); end
        cycle(1'b1, 1'b1, 1'b0, 16'hCAFE);
        total++; if ({stack_data, count, overflow} !== {16'hCAFE, 5'd16, 1'b1}) begin bad++; $display("FAIL full_repl2 got=%h/%0d/%b exp=CAFE/16/1", stack_data, count, overflow); end
        cycle(1'b1, 1'b1, 1'b0, first_exp);
        for (int i = 0; i < 16; i++) begin
            total++; if (stack_data !== first_exp - 16'(i)) begin bad++; $display("FAIL full_drain%0d got=%0d exp=%0d", i, stack_data, first_exp - 16'(i)); end
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
        total++; if ({empty, overflow, underflow} !== 3'b110) begin bad++; $display("FAIL full_end got=%b exp=110", {empty, overflow, underflow}); end
    endtask

    task automatic test_random();
        logic p, o, c;
        logic [W-1:0] d;
        int unsigned push_pct;
        cycle(1'b0, 1'b0, 1'b1, '0);
        for (int n = 0; n < 600; n++) begin
            // Alternate phases biased toward filling and toward draining
            push_pct = ((n / 60) % 2 == 0) ? 75 : 30;
            p = ($urandom_range(99) < push_pct);
            o = ($urandom_range(99) < 45);
            c = ($urandom_range(99) < 2);
            d = 16'($urandom);
            cycle(p, o, c, d);
            total++; if (stack_data !== m_top()) begin bad++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, stack_data, m_top()); end
            total++; if (count !== m_cnt()) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, m_cnt()); end
            total++; if ({empty, full} !== {mq.size() == 0, mq.size() == D}) begin bad++; $display("FAIL rnd_empty_full n=%0d got=%b exp=%b", n, {empty, full}, {mq.size() == 0, mq.size() == D}); end
            total++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin bad++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, {overflow, underflow}, {m_ovf, m_unf}); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_lifo();
        test_underflow();
        test_replace();
        test_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
